// File: rtl/jkarb_pkg.sv
// Shared definitions for the JK command arbiter: op codes, FSM state
// encoding, round-robin pick and JK next-state helpers.
package jkarb_pkg;

    // Op encoding is {J,K}
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_RST  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    // Upper bound on requesters the pick function can handle
    localparam int unsigned MAX_NREQ = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Returns {found, index}: first set bit of valid searching ptr+1, ptr+2, ...
    // modulo nreq.
    function automatic logic [3:0] rr_pick(input logic [MAX_NREQ-1:0] valid,
                                           input logic [2:0]          ptr,
                                           input int unsigned         nreq);
        logic [3:0]  res;
        int unsigned c;
        res = '0;
        for (int unsigned k = 1; k <= MAX_NREQ; k++) begin
            if (k <= nreq && !res[3]) begin
                c = (32'(ptr) + k) % nreq;
                if (valid[c[2:0]]) begin
                    res = {1'b1, c[2:0]};
                end
            end
        end
        return res;
    endfunction

    // Value a JK flip-flop takes after one edge with {J,K} = op
    function automatic logic jk_next(input logic [1:0] op, input logic cur);
        logic nxt;
        case (op)
            OP_HOLD: nxt = cur;
            OP_RST:  nxt = 1'b0;
            OP_SET:  nxt = 1'b1;
            default: nxt = ~cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_cmd_arbiter_if.sv
// Requester/status bundle for jk_cmd_arbiter. The req_lock lane exists only
// when JKARB_LOCK_EN is defined.
interface jk_cmd_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
);
    localparam int unsigned GIDW = $clog2(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [2*NREQ-1:0]    req_op;
    logic [IDXW*NREQ-1:0] req_idx;
`ifdef JKARB_LOCK_EN
    logic [NREQ-1:0]      req_lock;
`endif
    logic [WIDTH-1:0]     q;
    logic                 busy;
    logic                 done;
    logic [GIDW-1:0]      grant_id;
    logic                 rdata;
    logic                 err;

`ifdef JKARB_LOCK_EN
    modport master (
        output req_valid, req_op, req_idx, req_lock,
        input  req_ready, q, busy, done, grant_id, rdata, err
    );
    modport slave (
        input  req_valid, req_op, req_idx, req_lock,
        output req_ready, q, busy, done, grant_id, rdata, err
    );
`else
    modport master (
        output req_valid, req_op, req_idx,
        input  req_ready, q, busy, done, grant_id, rdata, err
    );
    modport slave (
        input  req_valid, req_op, req_idx,
        output req_ready, q, busy, done, grant_id, rdata, err
    );
`endif

endinterface

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH edge-triggered JK flip-flops, async active-high reset to 0.
// Pure storage: the sequencer above decides which J/K lines are driven.
module jk_reg_bank #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q
);

    // Per-bit JK update: 00 hold, 01 clear, 10 set, 11 toggle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                case ({j[i], k[i]})
                    2'b01:   q[i] <= 1'b0;
                    2'b10:   q[i] <= 1'b1;
                    2'b11:   q[i] <= ~q[i];
                    default: q[i] <= q[i];
                endcase
            end
        end
    end

endmodule

// File: rtl/jk_cmd_arbiter.sv
// Round-robin sequencer sharing one JK register bank between NREQ requesters.
// Each accepted command drives J/K of one bit for a single cycle, then pulses
// done with the resulting bit value. Define JKARB_LOCK_EN to let a winner
// lock the arbiter to itself for back-to-back commands.
module jk_cmd_arbiter
    import jkarb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic       clk,
    input  logic       rst,
    jk_cmd_arbiter_if.slave bus
);

    localparam int unsigned GIDW = $clog2(NREQ);

    state_e            state;
    logic [1:0]        op_q;
    logic [IDXW-1:0]   idx_q;
    logic [GIDW-1:0]   gid_q;
    logic [GIDW-1:0]   ptr_q;
    logic              busy_q;
    logic              done_q;
    logic              rdata_q;
    logic              err_q;

    logic [NREQ-1:0]   valid_eff;
    logic [3:0]        pick;
    logic              win_any;
    logic [GIDW-1:0]   win;
    logic              accept;
    logic [NREQ-1:0]   ready;
    logic [1:0]        op_sel;
    logic [IDXW-1:0]   idx_sel;
    logic              in_range;
    logic              rdata_d;
    logic [WIDTH-1:0]  bank_j;
    logic [WIDTH-1:0]  bank_k;
    logic [WIDTH-1:0]  bank_q;

`ifdef JKARB_LOCK_EN
    logic              lock_q;
    logic [GIDW-1:0]   owner_q;
    logic              lock_hold;

    // Lock survives only while the owner keeps both valid and lock asserted
    assign lock_hold = lock_q && bus.req_valid[owner_q] && bus.req_lock[owner_q];
`endif

    // Eligible requesters: everyone, or only the owner while the lock holds
    always_comb begin
        valid_eff = bus.req_valid;
`ifdef JKARB_LOCK_EN
        if (lock_hold) begin
            valid_eff          = '0;
            valid_eff[owner_q] = 1'b1;
        end
`endif
    end

    assign pick    = rr_pick(MAX_NREQ'(valid_eff), 3'(ptr_q), NREQ);
    assign win_any = pick[3];
    assign win     = GIDW'(pick[2:0]);
    assign accept  = (state == IDLE) && win_any;
    assign op_sel  = bus.req_op[2*win +: 2];
    assign idx_sel = bus.req_idx[IDXW*win +: IDXW];

    // Combinational ready to the winner, only while idle
    always_comb begin
        ready = '0;
        if (accept) begin
            ready[win] = 1'b1;
        end
    end

    assign in_range = (32'(idx_q) < WIDTH);

    // Drive J/K of the latched bit for the single APPLY cycle
    always_comb begin
        bank_j = '0;
        bank_k = '0;
        if (state == APPLY && in_range) begin
            bank_j[idx_q] = op_q[1];
            bank_k[idx_q] = op_q[0];
        end
    end

    // Post-edge value of the addressed bit, captured alongside the bank update
    always_comb begin
        rdata_d = 1'b0;
        if (in_range) begin
            rdata_d = jk_next(op_q, bank_q[idx_q]);
        end
    end

    jk_reg_bank #(
        .WIDTH(WIDTH)
    ) u_bank (
        .clk(clk),
        .rst(rst),
        .j  (bank_j),
        .k  (bank_k),
        .q  (bank_q)
    );

    // Command FSM with registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= OP_HOLD;
            idx_q   <= '0;
            gid_q   <= '0;
            ptr_q   <= GIDW'(NREQ - 1);
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef JKARB_LOCK_EN
            lock_q  <= 1'b0;
            owner_q <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= op_sel;
                        idx_q  <= idx_sel;
                        gid_q  <= win;
                        ptr_q  <= win;
                        busy_q <= 1'b1;
                        state  <= APPLY;
                    end
`ifdef JKARB_LOCK_EN
                    if (accept) begin
                        lock_q  <= bus.req_lock[win];
                        owner_q <= win;
                    end else if (!lock_hold) begin
                        lock_q  <= 1'b0;
                    end
`endif
                end
                APPLY: begin
                    done_q  <= 1'b1;
                    rdata_q <= rdata_d;
                    err_q   <= !in_range;
                    state   <= DONE;
                end
                DONE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.q         = bank_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.grant_id  = gid_q;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_jk_cmd_arbiter.sv
// Directed bench for jk_cmd_arbiter: an 8-bit instance for the main flows and
// a 6-bit instance for out-of-range indices. Lock flow when JKARB_LOCK_EN.
module tb_jk_cmd_arbiter;
    import jkarb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    jk_cmd_arbiter_if #(.NREQ(4), .WIDTH(8), .IDXW(3)) bus_a ();
    jk_cmd_arbiter_if #(.NREQ(4), .WIDTH(6), .IDXW(3)) bus_b ();

    jk_cmd_arbiter #(.NREQ(4), .WIDTH(8), .IDXW(3)) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a)
    );

    jk_cmd_arbiter #(.NREQ(4), .WIDTH(6), .IDXW(3)) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus_a.req_valid = '0;
        bus_a.req_op    = '0;
        bus_a.req_idx   = '0;
        bus_b.req_valid = '0;
        bus_b.req_op    = '0;
        bus_b.req_idx   = '0;
`ifdef JKARB_LOCK_EN
        bus_a.req_lock  = '0;
        bus_b.req_lock  = '0;
`endif
    endtask

    task automatic cmd_a(input int r, input logic [1:0] op, input logic [2:0] idx);
        bus_a.req_op[2*r +: 2]  = op;
        bus_a.req_idx[3*r +: 3] = idx;
        bus_a.req_valid[r]      = 1'b1;
    endtask

    task automatic cmd_b(input int r, input logic [1:0] op, input logic [2:0] idx);
        bus_b.req_op[2*r +: 2]  = op;
        bus_b.req_idx[3*r +: 3] = idx;
        bus_b.req_valid[r]      = 1'b1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_q;
        int         exp_w;

        rst = 1'b1;
        clear_reqs();
        @(posedge clk);
        #1;
        check_eq("rst_q", 32'(bus_a.q), 32'h0);
        check_eq("rst_busy", 32'(bus_a.busy), 32'h0);
        check_eq("rst_done", 32'(bus_a.done), 32'h0);
        check_eq("rst_gid", 32'(bus_a.grant_id), 32'h0);
        check_eq("rst_rdata", 32'(bus_a.rdata), 32'h0);
        check_eq("rst_err", 32'(bus_a.err), 32'h0);
        check_eq("rst_ready", 32'(bus_a.req_ready), 32'h0);
        check_eq("rst_q_b", 32'(bus_b.q), 32'h0);
        rst = 1'b0;
        step();

        // req0 set idx 3
        cmd_a(0, OP_SET, 3'd3);
        #1;
        check_eq("t1_ready", 32'(bus_a.req_ready), 32'h1);
        step();
        bus_a.req_valid[0] = 1'b0;
        check_eq("t1_busy", 32'(bus_a.busy), 32'h1);
        check_eq("t1_apply_done", 32'(bus_a.done), 32'h0);
        check_eq("t1_apply_ready", 32'(bus_a.req_ready), 32'h0);
        step();
        check_eq("t1_done", 32'(bus_a.done), 32'h1);
        check_eq("t1_q", 32'(bus_a.q), 32'h08);
        check_eq("t1_rdata", 32'(bus_a.rdata), 32'h1);
        check_eq("t1_gid", 32'(bus_a.grant_id), 32'h0);
        check_eq("t1_err", 32'(bus_a.err), 32'h0);
        step();
        check_eq("t1_idle_done", 32'(bus_a.done), 32'h0);
        check_eq("t1_idle_busy", 32'(bus_a.busy), 32'h0);

        // req1 toggles idx 3 twice, valid held throughout
        cmd_a(1, OP_TGL, 3'd3);
        #1;
        check_eq("t2_ready1", 32'(bus_a.req_ready), 32'h2);
        step();
        check_eq("t2_busy1", 32'(bus_a.busy), 32'h1);
        step();
        check_eq("t2_done1", 32'(bus_a.done), 32'h1);
        check_eq("t2_q1", 32'(bus_a.q), 32'h00);
        check_eq("t2_rdata1", 32'(bus_a.rdata), 32'h0);
        check_eq("t2_gid1", 32'(bus_a.grant_id), 32'h1);
        step();
        check_eq("t2_ready2", 32'(bus_a.req_ready), 32'h2);
        check_eq("t2_gap_done", 32'(bus_a.done), 32'h0);
        step();
        step();
        check_eq("t2_done2", 32'(bus_a.done), 32'h1);
        check_eq("t2_q2", 32'(bus_a.q), 32'h08);
        check_eq("t2_rdata2", 32'(bus_a.rdata), 32'h1);
        bus_a.req_valid[1] = 1'b0;
        step();

        // All four requesters valid: set idx r, expect 0,1,2,3,0
        pulse_reset();
        check_eq("t3_rst_q", 32'(bus_a.q), 32'h0);
        for (int r = 0; r < 4; r++) begin
            cmd_a(r, OP_SET, 3'(r));
        end
        exp_q = 8'h00;
        for (int i = 0; i < 5; i++) begin
            exp_w = i % 4;
            exp_q[exp_w] = 1'b1;
            #1;
            check_eq($sformatf("t3_ready%0d", i), 32'(bus_a.req_ready), 32'(1 << exp_w));
            step();
            check_eq($sformatf("t3_gid%0d", i), 32'(bus_a.grant_id), 32'(exp_w));
            step();
            check_eq($sformatf("t3_done%0d", i), 32'(bus_a.done), 32'h1);
            check_eq($sformatf("t3_q%0d", i), 32'(bus_a.q), 32'(exp_q));
            step();
        end
        check_eq("t3_q_final", 32'(bus_a.q), 32'h0F);
        clear_reqs();

        // WIDTH=6 instance: in-range set then out-of-range reset
        cmd_b(0, OP_SET, 3'd5);
        #1;
        check_eq("t4_ready0", 32'(bus_b.req_ready), 32'h1);
        step();
        bus_b.req_valid[0] = 1'b0;
        step();
        check_eq("t4_done0", 32'(bus_b.done), 32'h1);
        check_eq("t4_err0", 32'(bus_b.err), 32'h0);
        check_eq("t4_q0", 32'(bus_b.q), 32'h20);
        step();
        cmd_b(2, OP_RST, 3'd7);
        #1;
        check_eq("t4_ready2", 32'(bus_b.req_ready), 32'h4);
        step();
        bus_b.req_valid[2] = 1'b0;
        step();
        check_eq("t4_done2", 32'(bus_b.done), 32'h1);
        check_eq("t4_err2", 32'(bus_b.err), 32'h1);
        check_eq("t4_q2", 32'(bus_b.q), 32'h20);
        check_eq("t4_gid2", 32'(bus_b.grant_id), 32'h2);
        step();
        check_eq("t4_err_clear", 32'(bus_b.err), 32'h0);

        // Reset during APPLY aborts the command
        cmd_a(2, OP_SET, 3'd5);
        #1;
        check_eq("t5_ready", 32'(bus_a.req_ready), 32'h4);
        step();
        check_eq("t5_busy_pre", 32'(bus_a.busy), 32'h1);
        rst = 1'b1;
        #1;
        check_eq("t5_q", 32'(bus_a.q), 32'h0);
        check_eq("t5_busy", 32'(bus_a.busy), 32'h0);
        check_eq("t5_done", 32'(bus_a.done), 32'h0);
        step();
        check_eq("t5_no_done", 32'(bus_a.done), 32'h0);
        check_eq("t5_q_hold", 32'(bus_a.q), 32'h0);
        cmd_a(0, OP_SET, 3'd1);
        rst = 1'b0;
        #1;
        check_eq("t5_ready_r0", 32'(bus_a.req_ready), 32'h1);
        step();
        bus_a.req_valid = '0;
        step();
        check_eq("t5_done_r0", 32'(bus_a.done), 32'h1);
        check_eq("t5_q_r0", 32'(bus_a.q), 32'h02);
        check_eq("t5_gid_r0", 32'(bus_a.grant_id), 32'h0);
        step();
        clear_reqs();

`ifdef JKARB_LOCK_EN
        // req1 locks and toggles idx 7 three times while req0/req2 wait
        pulse_reset();
        cmd_a(1, OP_TGL, 3'd7);
        bus_a.req_lock[1] = 1'b1;
        #1;
        check_eq("t6_ready_first", 32'(bus_a.req_ready), 32'h2);
        step();
        cmd_a(0, OP_SET, 3'd0);
        cmd_a(2, OP_SET, 3'd2);
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            #1;
            check_eq($sformatf("t6_ready_lock%0d", i), 32'(bus_a.req_ready), 32'h2);
            step();
            check_eq($sformatf("t6_gid_lock%0d", i), 32'(bus_a.grant_id), 32'h1);
            step();
            step();
        end
        check_eq("t6_q_locked", 32'(bus_a.q), 32'h80);
        bus_a.req_lock[1] = 1'b0;
        #1;
        check_eq("t6_ready_after", 32'(bus_a.req_ready), 32'h4);
        step();
        check_eq("t6_gid_after", 32'(bus_a.grant_id), 32'h2);
        step();
        check_eq("t6_q_after", 32'(bus_a.q), 32'h84);
        step();
        clear_reqs();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jk_cmd_arbiter.md
Name: jk_cmd_arbiter

Overview:
- Shares one bank of WIDTH edge-triggered JK flip-flops between NREQ requesters.
- Each requester issues a JK command (hold/reset/set/toggle) to one bit index using a valid/ready handshake.
- A round-robin arbiter grants one command at a time. A 3-state FSM drives the J/K inputs of the addressed bit for exactly one cycle, then reports completion and the resulting bit value.
- Sits above the JK storage primitives as their sequencer.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, number of JK bits in the shared bank (1..32).
- IDXW, $clog2(WIDTH) (min 1), width of a bit index.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester command valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_op  input  2*NREQ  per-requester op {J,K}: 00 hold, 01 reset, 10 set, 11 toggle; requester r uses bits [2r+1:2r].
- req_idx  input  IDXW*NREQ  per-requester target bit index.
- req_lock  input  NREQ  lock request; present only with JKARB_LOCK_EN.
- q  output  WIDTH  current bank contents.
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle completion pulse.
- grant_id  output  $clog2(NREQ)  winner of the command in flight; valid while busy.
- rdata  output  1  post-command value of the addressed bit; valid when done=1.
- err  output  1  pulses with done when idx >= WIDTH.

Behaviour:
- Reset values (async on rst=1):
  - q=0, req_ready=0, busy=0, done=0, grant_id=0, rdata=0, err=0.
  - FSM returns to IDLE.
  - Round-robin pointer ptr=NREQ-1, so requester 0 has first priority.
  - Reset mid-command aborts it: no J/K applied, no done pulse.
- FSM states: IDLE, APPLY, DONE. Transitions: IDLE->APPLY when any req_valid; APPLY->DONE always; DONE->IDLE always.
- IDLE:
  - Winner w is the first r with req_valid[r]=1, searching ptr+1, ptr+2, ... modulo NREQ.
  - req_ready[w] is asserted combinationally in the same cycle. The handshake completes on valid&&ready.
  - On the next edge, op, idx and w are registered, ptr<=w, and state goes to APPLY.
- APPLY:
  - The bank bit at the latched idx sees J,K = latched op for this one cycle. All other bits see J=K=0.
  - On the closing edge: 00 holds, 01 clears to 0, 10 sets to 1, 11 inverts.
- DONE:
  - done=1 and rdata=q[idx] (updated value).
  - err=1 if idx >= WIDTH. In that case the command acted as hold and q is unchanged.
  - Next state is IDLE.
- Throughput: one command per 3 cycles. Latency from accept edge to done is 2 cycles.
- req_ready is 0 whenever state != IDLE. Requesters must hold valid, op and idx stable until ready.
- Simultaneous requests: exactly one is granted. The others wait, and round-robin guarantees each waits at most NREQ-1 grants.
- A request deasserted before ready is dropped silently.
- A hold op (00) still takes the full 3 cycles and pulses done.

Optional Feature:
- Macro: JKARB_LOCK_EN.
- With the macro:
  - req_lock port exists.
  - If the winner has req_lock=1 when it is accepted, a lock bit is set with owner=w.
  - While locked, IDLE grants only the owner and ignores other requesters even if they are valid.
  - The lock clears in any IDLE cycle where the owner has req_valid=0 or req_lock=0. Arbitration then resumes from ptr+1.
  - Reset clears the lock.
- Without the macro: no req_lock port and no lock state. Pure round-robin.

Decomposition:
- Package jkarb_pkg holds:
  - op localparams OP_HOLD=2'b00, OP_RST=2'b01, OP_SET=2'b10, OP_TGL=2'b11;
  - the state encoding (IDLE=0, APPLY=1, DONE=2);
  - a round-robin pick function.
- One sub-module, jk_reg_bank:
  - WIDTH JK flip-flops with per-bit J and K vectors, rising-edge clk, async active-high rst to 0.
  - Output q.
  - Contains no control logic.

Test Plan:
- Reset, then req0 set idx=3 -> req_ready[0] in cycle 0; done two cycles later; q=8'h08, rdata=1, grant_id=0.
- With q=8'h08, req1 toggles idx=3 twice in sequence -> q=8'h00 after first done (rdata=0), then q=8'h08 (rdata=1); each command spans exactly 3 cycles.
- All 4 requesters valid continuously with set idx=r -> grants in order 0,1,2,3,0; q reaches 8'h0F after 4 dones; no requester starved.
- WIDTH=6, req2 reset idx=7 -> err=1 with done; q unchanged.
- Assert rst during APPLY of a set -> q=0, busy=0, no done pulse; the next accept goes to requester 0 if its valid is asserted.
- JKARB_LOCK_EN: req1 locks and issues 3 commands while req0 and req2 stay valid -> grants 1,1,1; after req_lock[1] drops, the next grant is 2.
